// File: rtl/trig_pkg.sv
// trig_pkg: shared scheduler state encoding, default sizes and popcount helper.
// No ports; imported by trig_sched_if and trig_sched.
package trig_pkg;

    localparam int NPAIR_DEF = 8;
    localparam int CBITS_DEF = 16;
    localparam int PC_MAX    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COINC = 2'd1,
        FIRE  = 2'd2,
        DEAD  = 2'd3
    } state_t;

    function automatic logic [5:0] popcount(input logic [PC_MAX-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < PC_MAX; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/trig_sched_if.sv
// trig_sched_if: pair pulses, run configuration and trigger outputs of the scheduler.
// Modports: master drives pulses/config and reads results; slave is the scheduler side.
interface trig_sched_if
    import trig_pkg::*;
#(
    parameter int NPAIR = NPAIR_DEF,
    parameter int CBITS = CBITS_DEF
);
    logic [NPAIR-1:0] pair_trig;
    logic [NPAIR-1:0] mask;
    logic             enable;
    logic             busy;
    logic [3:0]       win;
    logic [3:0]       mult;
    logic [7:0]       prescale;
    logic [11:0]      deadtime;
    logic             trig;
    logic [NPAIR-1:0] trig_src;
    logic [CBITS-1:0] trig_cnt;
    logic [CBITS-1:0] lost_cnt;
    logic             inhibit;

    modport master (
        output pair_trig, mask, enable, busy, win, mult, prescale, deadtime,
        input  trig, trig_src, trig_cnt, lost_cnt, inhibit
    );

    modport slave (
        input  pair_trig, mask, enable, busy, win, mult, prescale, deadtime,
        output trig, trig_src, trig_cnt, lost_cnt, inhibit
    );

endinterface

// File: rtl/trig_satcnt.sv
// trig_satcnt: W-bit counter that increments on inc and holds at all-ones.
// Ports: clk, rst_n (async, active-low), inc, count.
module trig_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/trig_sched.sv
// trig_sched: window coincidence of pair triggers, prescale, dead time and inhibit.
// Ports: ADCCLK, RST_N (async, active-low), bus (trig_sched_if.slave).
module trig_sched
    import trig_pkg::*;
#(
    parameter int NPAIR = NPAIR_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input logic         ADCCLK,
    input logic         RST_N,
    trig_sched_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic [NPAIR-1:0] m;
    logic [NPAIR-1:0] pat_all;
    logic [NPAIR-1:0] pattern;
    logic [NPAIR-1:0] pattern_nx;
    logic [3:0]       wcnt;
    logic [3:0]       wcnt_nx;
    logic [7:0]       pscnt;
    logic [7:0]       pscnt_nx;
    logic [11:0]      dcnt;
    logic [11:0]      dcnt_nx;
    logic [3:0]       thr;
    logic [5:0]       pc;
    logic             pass;
    logic             lost_inc;
    logic             trig_r;
    logic [NPAIR-1:0] src_r;
    logic [CBITS-1:0] cnt_r;
    logic [CBITS-1:0] lost;
    logic             inh_r;

    assign m       = bus.pair_trig & bus.mask;
    // the evaluation cycle's own pulses still count toward the pattern
    assign pat_all = pattern | m;
    assign thr     = (bus.mult == 4'd0) ? 4'd1 : bus.mult;
    assign pc      = popcount(PC_MAX'(pat_all));
    assign pass    = pc >= {2'b00, thr};

    always_comb begin
        state_nx   = state;
        pattern_nx = pattern;
        wcnt_nx    = wcnt;
        pscnt_nx   = pscnt;
        dcnt_nx    = dcnt;
        unique case (state)
            IDLE: begin
                if (!bus.enable) begin
                    pscnt_nx = '0;
                end else if (!bus.busy && m != '0) begin
                    state_nx   = COINC;
                    pattern_nx = m;
                    wcnt_nx    = bus.win;
                end
            end
            COINC: begin
                if (!bus.enable) begin
                    state_nx = IDLE;
                    pscnt_nx = '0;
                end else begin
                    pattern_nx = pat_all;
                    if (wcnt != 4'd0) begin
                        wcnt_nx = wcnt - 4'd1;
                    end else if (!pass) begin
                        state_nx = IDLE;
                    end else if (pscnt == bus.prescale) begin
                        state_nx = FIRE;
                        pscnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                        pscnt_nx = pscnt + 8'd1;
                    end
                end
            end
            FIRE: begin
                state_nx = DEAD;
                dcnt_nx  = bus.deadtime;
            end
            DEAD: begin
                if (dcnt != 12'd0) begin
                    dcnt_nx = dcnt - 12'd1;
                end else if (!bus.busy) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ADCCLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            pattern <= '0;
            wcnt    <= '0;
            pscnt   <= '0;
            dcnt    <= '0;
            trig_r  <= 1'b0;
            src_r   <= '0;
            cnt_r   <= '0;
            inh_r   <= 1'b1;
        end else begin
            state   <= state_nx;
            pattern <= pattern_nx;
            wcnt    <= wcnt_nx;
            pscnt   <= pscnt_nx;
            dcnt    <= dcnt_nx;
            trig_r  <= state_nx == FIRE;
            if (state_nx == FIRE) begin
                src_r <= pat_all;
                cnt_r <= cnt_r + CBITS'(1);
            end
            // COINC is deliberately absent so other pairs keep firing
            inh_r <= state_nx == FIRE || state_nx == DEAD ||
                     !bus.enable || bus.busy;
        end
    end

    assign lost_inc = m != '0 &&
                      (state == FIRE || state == DEAD ||
                       (state == IDLE && bus.busy));

    trig_satcnt #(.W(CBITS)) u_lost (
        .clk   (ADCCLK),
        .rst_n (RST_N),
        .inc   (lost_inc),
        .count (lost)
    );

    assign bus.trig     = trig_r;
    assign bus.trig_src = src_r;
    assign bus.trig_cnt = cnt_r;
    assign bus.lost_cnt = lost;
    assign bus.inhibit  = inh_r;

endmodule
